// File: rtl/mist_spi_user_rx.sv
// SPI slave front end for the MiST IO controller's user-IO link: oversamples SCK/MOSI/SS in the
// clk50mhz domain, decodes buttons, joysticks and status, and queues PS/2 keyboard bytes.
module mist_spi_user_rx #(
  parameter logic [7:0]  CORE_TYPE      = 8'hA4,
  parameter int unsigned KBD_DEPTH_LOG2 = 3
) (
  input  logic        clk50mhz,
  input  logic        rst_n,
  input  logic        mist_sck,
  input  logic        mist_mosi,
  input  logic        mist_confdata0,
  output logic        mist_miso,
  output logic [1:0]  buttons,
  output logic [1:0]  switches,
  output logic [7:0]  joy0,
  output logic [7:0]  joy1,
  output logic [31:0] status,
  output logic        status_upd,
  output logic [7:0]  kbd_data,
  output logic        kbd_valid,
  input  logic        kbd_ack,
  output logic        kbd_ovf
);

  localparam int unsigned KbdDepth = 1 << KBD_DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  logic [1:0] sck_sync_q, mosi_sync_q, ss_sync_q;
  logic       sck_last_q, ss_last_q;
  logic       sck_rise, sck_fall, ss_fall, ss_high, mosi_bit;

  // SS synchroniser resets low so a frame already in progress at reset is never picked up.
  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      sck_last_q  <= 1'b0;
      ss_last_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], mist_sck};
      mosi_sync_q <= {mosi_sync_q[0], mist_mosi};
      ss_sync_q   <= {ss_sync_q[0], mist_confdata0};
      sck_last_q  <= sck_sync_q[1];
      ss_last_q   <= ss_sync_q[1];
    end
  end

  assign sck_rise = sck_sync_q[1] & ~sck_last_q;
  assign sck_fall = ~sck_sync_q[1] & sck_last_q;
  assign ss_fall  = ~ss_sync_q[1] & ss_last_q;
  assign ss_high  = ss_sync_q[1];
  assign mosi_bit = mosi_sync_q[1];

  state_e     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] bytecnt_q, bytecnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] cmd_q, cmd_d;
  logic       miso_q, miso_d;
  logic       byte_done;
  logic [7:0] rx_byte;

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    bytecnt_d = bytecnt_q;
    shift_d   = shift_q;
    cmd_d     = cmd_q;
    miso_d    = miso_q;
    byte_done = 1'b0;
    rx_byte   = {shift_q[6:0], mosi_bit};
    case (state_q)
      StIdle: begin
        bitcnt_d  = '0;
        bytecnt_d = '0;
        miso_d    = 1'b0;
        if (ss_fall) begin
          state_d = StCmd;
          miso_d  = CORE_TYPE[7];
        end
      end
      StCmd: begin
        if (sck_rise) begin
          shift_d  = rx_byte;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            cmd_d     = rx_byte;
            state_d   = StData;
            bytecnt_d = '0;
            miso_d    = 1'b0;
          end
        end else if (sck_fall) begin
          // After k rising edges the master expects CORE_TYPE bit 7-k.
          miso_d = CORE_TYPE[~bitcnt_q];
        end
      end
      StData: begin
        miso_d = 1'b0;
        if (sck_rise) begin
          shift_d  = rx_byte;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            byte_done = 1'b1;
            if (bytecnt_q != 8'hFF) bytecnt_d = bytecnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (ss_high && state_q != StIdle) begin
      state_d   = StIdle;
      bitcnt_d  = '0;
      bytecnt_d = '0;
      miso_d    = 1'b0;
      byte_done = 1'b0;
    end
  end

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bitcnt_q  <= '0;
      bytecnt_q <= '0;
      shift_q   <= '0;
      cmd_q     <= '0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      bytecnt_q <= bytecnt_d;
      shift_q   <= shift_d;
      cmd_q     <= cmd_d;
      miso_q    <= miso_d;
    end
  end

  assign mist_miso = miso_q;

  logic [23:0] shadow_q;

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      buttons    <= '0;
      switches   <= '0;
      joy0       <= '0;
      joy1       <= '0;
      status     <= '0;
      status_upd <= 1'b0;
      shadow_q   <= '0;
    end else begin
      status_upd <= 1'b0;
      if (byte_done) begin
        case (cmd_q)
          8'h01: if (bytecnt_q == 8'd0) {switches, buttons} <= rx_byte[3:0];
          8'h02: if (bytecnt_q == 8'd0) joy0 <= rx_byte;
          8'h03: if (bytecnt_q == 8'd0) joy1 <= rx_byte;
          8'h1E: begin
            if (bytecnt_q < 8'd3) begin
              shadow_q[{bytecnt_q[1:0], 3'b000} +: 8] <= rx_byte;
            end else if (bytecnt_q == 8'd3) begin
              status     <= {rx_byte, shadow_q};
              status_upd <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [KBD_DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]              kbd_mem_q [KbdDepth];
  logic                    kbd_push, kbd_pop, kbd_full, push_ok;

  assign kbd_push  = byte_done && (cmd_q == 8'h05);
  assign kbd_valid = (wr_ptr_q != rd_ptr_q);
  assign kbd_full  = (wr_ptr_q[KBD_DEPTH_LOG2] != rd_ptr_q[KBD_DEPTH_LOG2]) &&
                     (wr_ptr_q[KBD_DEPTH_LOG2-1:0] == rd_ptr_q[KBD_DEPTH_LOG2-1:0]);
  assign kbd_pop   = kbd_valid && kbd_ack;
  // A same-cycle pop frees the head slot, which is exactly where a full FIFO writes.
  assign push_ok   = kbd_push && (!kbd_full || kbd_pop);
  assign kbd_data  = kbd_mem_q[rd_ptr_q[KBD_DEPTH_LOG2-1:0]];

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      kbd_ovf  <= 1'b0;
      for (int i = 0; i < KbdDepth; i++) kbd_mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        kbd_mem_q[wr_ptr_q[KBD_DEPTH_LOG2-1:0]] <= rx_byte;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (kbd_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (kbd_push && kbd_full && !kbd_pop) kbd_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mist_spi_user_rx.sv
// Directed, table-driven bench for mist_spi_user_rx: SPI frames at 5 MHz and 12.5 MHz.
module tb_mist_spi_user_rx;

  logic        clk50mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        mist_sck = 1'b0;
  logic        mist_mosi = 1'b0;
  logic        mist_confdata0 = 1'b1;
  logic        mist_miso;
  logic [1:0]  buttons, switches;
  logic [7:0]  joy0, joy1, kbd_data;
  logic [31:0] status;
  logic        status_upd, kbd_valid, kbd_ovf;
  logic        kbd_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;

  mist_spi_user_rx dut (
    .clk50mhz      (clk50mhz),
    .rst_n         (rst_n),
    .mist_sck      (mist_sck),
    .mist_mosi     (mist_mosi),
    .mist_confdata0(mist_confdata0),
    .mist_miso     (mist_miso),
    .buttons       (buttons),
    .switches      (switches),
    .joy0          (joy0),
    .joy1          (joy1),
    .status        (status),
    .status_upd    (status_upd),
    .kbd_data      (kbd_data),
    .kbd_valid     (kbd_valid),
    .kbd_ack       (kbd_ack),
    .kbd_ovf       (kbd_ovf)
  );

  always #10 clk50mhz = ~clk50mhz;

  always @(posedge clk50mhz) if (status_upd === 1'b1) upd_cnt++;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] data;
    int          n;
    logic [1:0]  b;
    logic [1:0]  s;
    logic [7:0]  j0;
    logic [7:0]  j1;
    logic [31:0] st;
    int          upd;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int half, input bit ack_last,
                          output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mist_mosi = tx[i];
      #(half);
      rx[i] = mist_miso;
      mist_sck = 1'b1;
      if (ack_last && i == 0) begin
        // Ack covers only the clock edge on which this byte commits.
        #40 kbd_ack = 1'b1;
        #20 kbd_ack = 1'b0;
        #(half - 60);
      end else begin
        #(half);
      end
      mist_sck = 1'b0;
    end
  endtask

  task automatic spi_bit(input logic b, input int half);
    mist_mosi = b;
    #(half) mist_sck = 1'b1;
    #(half) mist_sck = 1'b0;
  endtask

  task automatic frame_start();
    @(negedge clk50mhz);
    mist_confdata0 = 1'b0;
    #200;
  endtask

  task automatic frame_end(input int half);
    #(half) mist_confdata0 = 1'b1;
    #200;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] data, input int n,
                            input int half, output logic [7:0] cmd_rx);
    logic [7:0] rx;
    frame_start();
    spi_byte(cmd, half, 1'b0, cmd_rx);
    for (int j = 0; j < n; j++) spi_byte(data[8*j +: 8], half, 1'b0, rx);
    frame_end(half);
  endtask

  task automatic do_reset();
    @(negedge clk50mhz) rst_n = 1'b0;
    #40;
    @(negedge clk50mhz) rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_buttons"}, {30'd0, buttons}, 32'd0);
    chk({nm, "_switches"}, {30'd0, switches}, 32'd0);
    chk({nm, "_joy0"}, {24'd0, joy0}, 32'd0);
    chk({nm, "_joy1"}, {24'd0, joy1}, 32'd0);
    chk({nm, "_status"}, status, 32'd0);
    chk({nm, "_status_upd"}, {31'd0, status_upd}, 32'd0);
    chk({nm, "_kbd_data"}, {24'd0, kbd_data}, 32'd0);
    chk({nm, "_kbd_valid"}, {31'd0, kbd_valid}, 32'd0);
    chk({nm, "_kbd_ovf"}, {31'd0, kbd_ovf}, 32'd0);
    chk({nm, "_miso"}, {31'd0, mist_miso}, 32'd0);
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    @(negedge clk50mhz);
    chk({nm, "_valid"}, {31'd0, kbd_valid}, 32'd1);
    chk(nm, {24'd0, kbd_data}, {24'd0, exp});
    kbd_ack = 1'b1;
    @(negedge clk50mhz);
    kbd_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] m0, m1, c, d;
    int         n, upd0;

    vecs[0] = '{8'h01, 32'h0000_000D, 1, 2'b01, 2'b11, 8'h00, 8'h00, 32'h0, 0};
    vecs[1] = '{8'h02, 32'h0000_FF3C, 2, 2'b01, 2'b11, 8'h3C, 8'h00, 32'h0, 0};
    vecs[2] = '{8'h03, 32'h0000_00C3, 1, 2'b01, 2'b11, 8'h3C, 8'hC3, 32'h0, 0};
    vecs[3] = '{8'h1E, 32'h1234_5678, 4, 2'b01, 2'b11, 8'h3C, 8'hC3, 32'h1234_5678, 1};
    vecs[4] = '{8'h1E, 32'h00CC_BBAA, 3, 2'b01, 2'b11, 8'h3C, 8'hC3, 32'h1234_5678, 0};
    vecs[5] = '{8'h07, 32'h0000_2211, 2, 2'b01, 2'b11, 8'h3C, 8'hC3, 32'h1234_5678, 0};
    vecs[6] = '{8'h01, 32'h0000_33F2, 2, 2'b10, 2'b00, 8'h3C, 8'hC3, 32'h1234_5678, 0};

    #55;
    chk_all_zero("reset");
    @(negedge clk50mhz) rst_n = 1'b1;

    foreach (vecs[i]) begin
      upd0 = upd_cnt;
      send_frame(vecs[i].cmd, vecs[i].data, vecs[i].n, 100, rx);
      if (i == 0) chk("miso_core_type", {24'd0, rx}, 32'h0000_00A4);
      chk($sformatf("v%0d_buttons", i), {30'd0, buttons}, {30'd0, vecs[i].b});
      chk($sformatf("v%0d_switches", i), {30'd0, switches}, {30'd0, vecs[i].s});
      chk($sformatf("v%0d_joy0", i), {24'd0, joy0}, {24'd0, vecs[i].j0});
      chk($sformatf("v%0d_joy1", i), {24'd0, joy1}, {24'd0, vecs[i].j1});
      chk($sformatf("v%0d_status", i), status, vecs[i].st);
      chk($sformatf("v%0d_upd_pulses", i), upd_cnt - upd0, vecs[i].upd);
    end

    // Overflow: ten bytes into an eight-deep FIFO with no pops.
    frame_start();
    spi_byte(8'h05, 100, 1'b0, rx);
    for (int j = 0; j < 10; j++) spi_byte(8'h10 + 8'(j), 100, 1'b0, rx);
    frame_end(100);
    chk("ovf_valid", {31'd0, kbd_valid}, 32'd1);
    chk("ovf_flag", {31'd0, kbd_ovf}, 32'd1);
    for (int j = 0; j < 8; j++) pop_chk($sformatf("ovf_pop%0d", j), 8'h10 + 8'(j));
    @(negedge clk50mhz);
    chk("ovf_drained", {31'd0, kbd_valid}, 32'd0);
    kbd_ack = 1'b1;
    @(negedge clk50mhz) kbd_ack = 1'b0;
    chk("ack_empty_ignored", {31'd0, kbd_valid}, 32'd0);

    // Full FIFO with a pop on the very cycle 0x55 commits.
    do_reset();
    frame_start();
    spi_byte(8'h05, 100, 1'b0, rx);
    for (int j = 0; j < 8; j++) spi_byte(8'h20 + 8'(j), 100, 1'b0, rx);
    spi_byte(8'h55, 100, 1'b1, rx);
    frame_end(100);
    chk("full_pop_ovf", {31'd0, kbd_ovf}, 32'd0);
    for (int j = 1; j < 8; j++) pop_chk($sformatf("full_pop%0d", j), 8'h20 + 8'(j));
    pop_chk("full_pop_last", 8'h55);
    @(negedge clk50mhz);
    chk("full_drained", {31'd0, kbd_valid}, 32'd0);

    // Partial joy0 byte is discarded.
    send_frame(8'h02, 32'h3C, 1, 100, rx);
    frame_start();
    spi_byte(8'h02, 100, 1'b0, rx);
    for (int j = 0; j < 5; j++) spi_bit(1'b1, 100);
    frame_end(100);
    chk("partial_joy0_kept", {24'd0, joy0}, 32'h3C);
    send_frame(8'h02, 32'hA5, 1, 100, rx);
    chk("joy0_after_partial", {24'd0, joy0}, 32'hA5);

    // Asynchronous reset mid-byte; the rest of the frame must be ignored.
    send_frame(8'h01, 32'h06, 1, 100, rx);
    send_frame(8'h1E, 32'hDEAD_BEEF, 4, 100, rx);
    chk("pre_rst_status", status, 32'hDEAD_BEEF);
    frame_start();
    spi_byte(8'h03, 100, 1'b0, rx);
    for (int j = 0; j < 3; j++) spi_bit(1'b1, 100);
    #3 rst_n = 1'b0;
    #3 chk_all_zero("midrst");
    @(negedge clk50mhz) rst_n = 1'b1;
    for (int j = 0; j < 5; j++) spi_bit(1'b0, 100);
    spi_byte(8'h03, 100, 1'b0, rx);
    spi_byte(8'h77, 100, 1'b0, rx);
    frame_end(100);
    chk("no_resync_joy1", {24'd0, joy1}, 32'd0);
    chk("no_resync_joy0", {24'd0, joy0}, 32'd0);

    // Random frames at 12.5 MHz SCK.
    m0 = 8'h00;
    m1 = 8'h00;
    for (int f = 0; f < 8; f++) begin
      c = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'h03;
      n = $urandom_range(1, 3);
      frame_start();
      spi_byte(c, 40, 1'b0, rx);
      for (int j = 0; j < n; j++) begin
        d = 8'($urandom);
        if (j == 0) begin
          if (c == 8'h02) m0 = d;
          else m1 = d;
        end
        spi_byte(d, 40, 1'b0, rx);
      end
      frame_end(40);
      chk($sformatf("fast%0d_joy0", f), {24'd0, joy0}, {24'd0, m0});
      chk($sformatf("fast%0d_joy1", f), {24'd0, joy1}, {24'd0, m1});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
